// File: rtl/uart_rx.sv
// 16x-oversampling 8N1 serial receiver with bus-mapped period/data/status registers
// and an internal byte FIFO that raises rx_avail while it holds data.
module uart_rx #(
    parameter logic [7:0] PERIOD     = 8'h1A,
    parameter int         FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wren,
    input  logic       rden,
    input  logic [2:0] addr,
    input  logic [7:0] din,
    input  logic       rxin,
    output logic [7:0] dout,
    output logic       rx_avail
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
    state_t state, state_next;

    logic       rx_m, rx_s;
    logic [7:0] period, per_act;
    logic [8:0] presc;
    logic       tick;
    logic [3:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count, count_next;
    logic        empty, full, pop, push, push_req, frame_set, ovr_set, bit_tick;
    logic        frame_err, overrun;
    logic        period_wr, status_wr;
    logic [7:0]  status;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rxin;
            rx_s <= rx_m;
        end
    end

    // Tick every 2*(per_act+1) clocks; the active period reloads in IDLE and on each wrap.
    assign tick = (state != IDLE) && (presc == {per_act, 1'b1});

    always_ff @(posedge clk) begin
        if (reset) begin
            presc   <= '0;
            per_act <= PERIOD;
        end else begin
            if (state == IDLE || tick) presc <= '0;
            else                       presc <= presc + 9'd1;
            if (state == IDLE || tick) per_act <= period;
        end
    end

    assign bit_tick = tick && (tick_cnt == 4'd15);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!rx_s) state_next = START;
            START:   if (tick && tick_cnt == 4'd7) state_next = rx_s ? IDLE : DATA;
            DATA:    if (bit_tick && bit_cnt == 3'd7) state_next = STOP;
            STOP:    if (bit_tick) state_next = rx_s ? IDLE : BRK;
            BRK:     if (rx_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        push_req  = 1'b0;
        frame_set = 1'b0;
        if (state == STOP && bit_tick) begin
            push_req  = rx_s;
            frame_set = !rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                end
                START: if (tick) tick_cnt <= (tick_cnt == 4'd7) ? 4'd0 : tick_cnt + 4'd1;
                DATA: begin
                    if (tick) tick_cnt <= tick_cnt + 4'd1;
                    if (bit_tick) begin
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                STOP:    if (tick) tick_cnt <= tick_cnt + 4'd1;
                default: ;
            endcase
        end
    end

    assign empty      = (count == '0);
    assign full       = (count == DEPTH_C);
    assign pop        = rden && (addr == 3'd1) && !empty;
    // A pop in the same clock frees the slot, so a full FIFO still accepts the byte.
    assign push       = push_req && (!full || pop);
    assign ovr_set    = push_req && full && !pop;
    assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);
    assign period_wr  = wren && (addr == 3'd0);
    assign status_wr  = wren && (addr == 3'd3);
    assign status     = {4'b0, full, overrun, frame_err, !empty};

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rx_avail  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            period    <= PERIOD;
            dout      <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count     <= count_next;
            rx_avail  <= (count_next != '0);
            frame_err <= frame_set | (frame_err & ~(status_wr & din[1]));
            overrun   <= ovr_set | (overrun & ~(status_wr & din[2]));
            if (period_wr) period <= din;
            if (rden) begin
                case (addr)
                    3'd0:    dout <= period;
                    3'd1:    dout <= empty ? 8'h00 : mem[rd_ptr];
                    3'd3:    dout <= status;
                    default: dout <= 8'h00;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: framing, glitch rejection, break, FIFO overrun,
// period change and mid-frame reset.
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       reset;
    logic       wren, rden;
    logic [2:0] addr;
    logic [7:0] din;
    logic       rxin;
    logic [7:0] dout;
    logic       rx_avail;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx dut (
        .clk(clk), .reset(reset), .wren(wren), .rden(rden), .addr(addr),
        .din(din), .rxin(rxin), .dout(dout), .rx_avail(rx_avail)
    );

    always #5 clk = ~clk;

    task automatic idle_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a; rden = 1'b1;
        @(negedge clk);
        rden = 1'b0;
        d = dout;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] v);
        @(negedge clk);
        addr = a; din = v; wren = 1'b1;
        @(negedge clk);
        wren = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int cpb);
        @(negedge clk);
        rxin = 1'b0;
        idle_clks(cpb);
        for (int i = 0; i < 8; i++) begin
            rxin = b[i];
            idle_clks(cpb);
        end
        rxin = stop;
        idle_clks(cpb);
    endtask

    task automatic test_reset;
        logic [7:0] d;
        n_checks++;
        if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
        n_checks++;
        if (rx_avail !== 1'b0) begin n_fail++; $display("FAIL reset_avail: got %b want 0", rx_avail); end
        bus_read(3'd0, d);
        n_checks++;
        if (d !== 8'h1A) begin n_fail++; $display("FAIL reset_period: got %h want 1a", d); end
        bus_read(3'd3, d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h want 00", d); end
    endtask

    task automatic test_basic_rx;
        logic [7:0] d;
        send_byte(8'h55, 1'b1, 864);
        n_checks++;
        if (rx_avail !== 1'b1) begin n_fail++; $display("FAIL basic_avail_set: got %b want 1", rx_avail); end
        bus_read(3'd1, d);
        n_checks++;
        if (d !== 8'h55) begin n_fail++; $display("FAIL basic_data: got %h want 55", d); end
        n_checks++;
        if (rx_avail !== 1'b0) begin n_fail++; $display("FAIL basic_avail_clr: got %b want 0", rx_avail); end
        bus_read(3'd3, d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL basic_status: got %h want 00", d); end
        bus_read(3'd2, d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL reg2_read: got %h want 00", d); end
    endtask

    task automatic test_glitch;
        logic [7:0] d;
        @(negedge clk);
        rxin = 1'b0;
        idle_clks(259);
        rxin = 1'b1;
        idle_clks(1000);
        n_checks++;
        if (dut.state !== 3'd0) begin n_fail++; $display("FAIL glitch_state: got %0d want 0", dut.state); end
        n_checks++;
        if (rx_avail !== 1'b0) begin n_fail++; $display("FAIL glitch_avail: got %b want 0", rx_avail); end
        bus_read(3'd3, d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL glitch_status: got %h want 00", d); end
    endtask

    task automatic test_break;
        logic [7:0] d;
        send_byte(8'hA3, 1'b0, 864);
        idle_clks(1728);
        bus_read(3'd3, d);
        n_checks++;
        if (d !== 8'h02) begin n_fail++; $display("FAIL break_status: got %h want 02", d); end
        rxin = 1'b1;
        idle_clks(864);
        send_byte(8'h3C, 1'b1, 864);
        idle_clks(20);
        bus_read(3'd3, d);
        n_checks++;
        if (d !== 8'h03) begin n_fail++; $display("FAIL break_status2: got %h want 03", d); end
        bus_read(3'd1, d);
        n_checks++;
        if (d !== 8'h3C) begin n_fail++; $display("FAIL break_next_data: got %h want 3c", d); end
        bus_write(3'd3, 8'h02);
        bus_read(3'd3, d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL break_clear: got %h want 00", d); end
    endtask

    task automatic test_period;
        logic [7:0] d;
        bus_write(3'd0, 8'h0C);
        bus_read(3'd0, d);
        n_checks++;
        if (d !== 8'h0C) begin n_fail++; $display("FAIL period_read: got %h want 0c", d); end
        send_byte(8'h96, 1'b1, 432);
        idle_clks(20);
        bus_read(3'd1, d);
        n_checks++;
        if (d !== 8'h96) begin n_fail++; $display("FAIL period_data: got %h want 96", d); end
    endtask

    task automatic test_overrun;
        logic [7:0] d;
        bus_write(3'd0, 8'h03);
        for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1, 128);
        idle_clks(20);
        bus_read(3'd3, d);
        n_checks++;
        if (d !== 8'h0D) begin n_fail++; $display("FAIL overrun_status: got %h want 0d", d); end
        for (int i = 0; i < 16; i++) begin
            bus_read(3'd1, d);
            n_checks++;
            if (d !== 8'(i)) begin n_fail++; $display("FAIL overrun_data%0d: got %h want %h", i, d, 8'(i)); end
        end
        n_checks++;
        if (rx_avail !== 1'b0) begin n_fail++; $display("FAIL drained_avail: got %b want 0", rx_avail); end
        bus_read(3'd1, d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL empty_read: got %h want 00", d); end
        bus_write(3'd3, 8'h04);
        bus_read(3'd3, d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL overrun_clear: got %h want 00", d); end
    endtask

    task automatic test_mid_reset;
        logic [7:0] d;
        @(negedge clk);
        rxin = 1'b0;
        idle_clks(128);
        for (int i = 0; i < 4; i++) begin
            rxin = 1'b1;
            idle_clks(128);
        end
        rxin = 1'b0;
        idle_clks(64);
        n_checks++;
        if (dut.state !== 3'd2) begin n_fail++; $display("FAIL midrst_in_data: got %0d want 2", dut.state); end
        reset = 1'b1;
        rxin  = 1'b1;
        idle_clks(3);
        reset = 1'b0;
        idle_clks(1);
        n_checks++;
        if (dut.state !== 3'd0) begin n_fail++; $display("FAIL midrst_state: got %0d want 0", dut.state); end
        n_checks++;
        if (dout !== 8'h00) begin n_fail++; $display("FAIL midrst_dout: got %h want 00", dout); end
        n_checks++;
        if (rx_avail !== 1'b0) begin n_fail++; $display("FAIL midrst_avail: got %b want 0", rx_avail); end
        bus_read(3'd0, d);
        n_checks++;
        if (d !== 8'h1A) begin n_fail++; $display("FAIL midrst_period: got %h want 1a", d); end
        idle_clks(2000);
        bus_read(3'd3, d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL midrst_status: got %h want 00", d); end
    endtask

    initial begin
        reset = 1'b1; wren = 1'b0; rden = 1'b0; addr = 3'd0; din = 8'h00; rxin = 1'b1;
        idle_clks(4);
        reset = 1'b0;
        idle_clks(2);
        test_reset();
        test_basic_rx();
        test_glitch();
        test_break();
        test_period();
        test_overrun();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
